// File: rtl/ah_gnt_burst_if.sv
// Handshake bundle between the LRU arbiter, the requesters and the burst controller.
// The slave modport is the controller's view; master is the environment's view.
interface ah_gnt_burst_if #(
    parameter int unsigned NREQ = 7,
    parameter int unsigned DW   = 32,
    parameter int unsigned LENW = 4,
    parameter int unsigned SRCW = 3
) ();
    logic [NREQ-1:0]      arb_gnt;
    logic [NREQ-1:0]      arb_busy;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [SRCW-1:0]      out_src;
    logic                 out_last;
    logic                 out_ready;
    logic                 multi_gnt_err;

    modport master (
        output arb_gnt, req_valid, req_len, req_data, out_ready,
        input  arb_busy, req_ready, out_valid, out_data, out_src, out_last, multi_gnt_err
    );

    modport slave (
        input  arb_gnt, req_valid, req_len, req_data, out_ready,
        output arb_busy, req_ready, out_valid, out_data, out_src, out_last, multi_gnt_err
    );
endinterface

// File: rtl/ah_gnt_burst_ctrl.sv
// Burst stage behind the LRU arbiter: latches a grant, locks the output channel to that
// requester for req_len+1 beats and holds the arbiter off via arb_busy meanwhile.
module ah_gnt_burst_ctrl #(
    parameter int unsigned NREQ = 7,
    parameter int unsigned DW   = 32,
    parameter int unsigned LENW = 4,
    parameter int unsigned SRCW = 3
) (
    input  logic          clk,
    input  logic          rst,
    ah_gnt_burst_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [SRCW-1:0] owner_q, owner_d;
    logic [LENW-1:0] beats_left_q, beats_left_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] gnt;
    logic [SRCW-1:0] gnt_idx;
    logic [LENW-1:0] gnt_len;
    logic            gnt_multi;

    logic            in_burst;
    logic            own_valid;
    logic [DW-1:0]   own_data;
    logic            out_valid;
    logic            fire;

    // Lowest set grant bit wins; a multi-hot grant is flagged but otherwise tolerated.
    always_comb begin
        gnt     = bus.arb_gnt;
        gnt_idx = '0;
        gnt_len = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                gnt_idx = SRCW'(i);
                gnt_len = bus.req_len[i*LENW +: LENW];
            end
        end
        gnt_multi = (gnt & (gnt - NREQ'(1))) != '0;
    end

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == SRCW'(i)) begin
                own_valid = bus.req_valid[i];
                own_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign in_burst = (state_q == StBurst);
    assign out_valid = in_burst & own_valid;
    assign fire = out_valid & bus.out_ready;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = in_burst && (owner_q == SRCW'(i)) && bus.out_ready;
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.out_data      = own_data;
    assign bus.out_src       = owner_q;
    assign bus.out_last      = out_valid & (beats_left_q == '0);
    assign bus.arb_busy      = {NREQ{busy_q}};
    assign bus.multi_gnt_err = err_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (gnt != '0) begin
                    state_d      = StBurst;
                    owner_d      = gnt_idx;
                    beats_left_d = gnt_len;
                    if (gnt_multi) begin
                        err_d = 1'b1;
                    end
                end
            end
            StBurst: begin
                // beats_left only counts down while nonzero, so it can never wrap.
                if (fire) begin
                    if (beats_left_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        beats_left_d = beats_left_q - LENW'(1);
                    end
                end
            end
        endcase
        // Busy is a flop tracking the next state so the arbiter sees a clean level.
        busy_d = (state_d == StBurst);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            beats_left_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_ah_gnt_burst_ctrl.sv
// Directed bench for ah_gnt_burst_ctrl: a transaction-level model checked every cycle,
// plus hand-computed beat logs and literal spot checks per scenario.
module tb_ah_gnt_burst_ctrl;
    localparam int unsigned NREQ = 7;
    localparam int unsigned DW   = 32;
    localparam int unsigned LENW = 4;
    localparam int unsigned SRCW = 3;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ah_gnt_burst_if #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .SRCW(SRCW)) bus ();

    ah_gnt_burst_ctrl #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .SRCW(SRCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    bit    started = 0;
    bit    m_busy = 0;
    int    m_owner = 0;
    int    m_rem = 0;
    bit    m_err = 0;
    beat_t log_q[$];
    int    seq[NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (m_busy && k < bound) begin
            step();
            k++;
        end
        chk("burst_done", 64'(bus.arb_busy), 64'd0);
    endtask

    task automatic chk_log(input int n, input int src, input int seq0);
        chk("beat_count", 64'(log_q.size()), 64'(n));
        for (int k = 0; k < log_q.size() && k < n; k++) begin
            chk("beat_data", 64'(log_q[k].data), 64'({8'(src), 24'(seq0 + k)}));
            chk("beat_last", 64'(log_q[k].last), 64'(k == n - 1));
        end
        log_q.delete();
    endtask

    // Requester sources: each payload is {index, sequence}, advancing on every accepted beat.
    initial begin
        logic [NREQ-1:0] acc;
        for (int i = 0; i < NREQ; i++) begin
            seq[i] = 0;
            bus.req_data[i*DW +: DW] = {8'(i), 24'(0)};
        end
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) seq[i]++;
                bus.req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
            end
        end
    end

    // Model: a burst owns the channel until (len+1) accepted beats have been counted out.
    initial begin
        logic            exp_valid;
        logic [NREQ-1:0] exp_ready;
        forever begin
            @(negedge clk);
            exp_valid = m_busy && bus.req_valid[m_owner];
            exp_ready = (m_busy && bus.out_ready) ? (NREQ'(1) << m_owner) : '0;
            if (started) begin
                chk("arb_busy", 64'(bus.arb_busy), m_busy ? 64'h7F : 64'd0);
                chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
                chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
                chk("out_last", 64'(bus.out_last), 64'(exp_valid && m_rem == 1));
                chk("out_src", 64'(bus.out_src), 64'(m_owner));
                chk("multi_gnt_err", 64'(bus.multi_gnt_err), 64'(m_err));
                if (exp_valid) begin
                    chk("out_data", 64'(bus.out_data), 64'(bus.req_data[m_owner*DW +: DW]));
                end
            end
            if (rst) begin
                m_busy = 0;
                m_owner = 0;
                m_rem = 0;
                m_err = 0;
                started = 1;
            end else if (!m_busy) begin
                if (bus.arb_gnt != '0) begin
                    for (int i = NREQ - 1; i >= 0; i--) if (bus.arb_gnt[i]) m_owner = i;
                    m_rem = int'(bus.req_len[m_owner*LENW +: LENW]) + 1;
                    m_busy = 1;
                    if ($countones(bus.arb_gnt) > 1) m_err = 1;
                end
            end else if (exp_valid && bus.out_ready) begin
                log_q.push_back('{src: m_owner, data: bus.out_data, last: bus.out_last});
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [7];
        int         busy_cycles;
        pat = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11};

        bus.arb_gnt   = '0;
        bus.req_valid = '0;
        bus.req_len   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(bus.arb_busy), 64'd0);
        chk("rst_src", 64'(bus.out_src), 64'd0);
        rst = 1'b0;

        // Single burst: requester 2, four beats.
        bus.req_len[2*LENW +: LENW] = 4'd3;
        bus.req_valid[2] = 1'b1;
        bus.out_ready = 1'b1;
        bus.arb_gnt = 7'b0000100;
        step();
        bus.arb_gnt = '0;
        chk("t1_busy_on", 64'(bus.arb_busy), 64'h7F);
        busy_cycles = 1;
        while (bus.arb_busy != '0 && busy_cycles < 20) begin
            step();
            if (bus.arb_busy != '0) busy_cycles++;
        end
        chk("t1_busy_cycles", 64'(busy_cycles), 64'd4);
        wait_idle(4);
        chk_log(4, 2, 0);
        bus.req_valid = '0;

        // Back-pressure and source stalls: requester 5, three beats.
        bus.req_len[5*LENW +: LENW] = 4'd2;
        bus.req_valid[5] = 1'b1;
        bus.arb_gnt = 7'b0100000;
        step();
        bus.arb_gnt = '0;
        for (int c = 0; c < 7; c++) begin
            bus.out_ready    = pat[c][1];
            bus.req_valid[5] = pat[c][0];
            if (c == 2) begin
                #1;
                chk("t2_ready_stall", 64'(bus.req_ready), 64'h20);
            end
            step();
        end
        wait_idle(4);
        chk_log(3, 5, 0);
        bus.req_valid = '0;
        bus.out_ready = 1'b1;

        // Single-beat burst, then an immediate grant to requester 6.
        bus.req_len[0*LENW +: LENW] = 4'd0;
        bus.req_valid[0] = 1'b1;
        bus.arb_gnt = 7'b0000001;
        step();
        bus.arb_gnt = '0;
        chk("t3_last", 64'(bus.out_last), 64'd1);
        step();
        chk("t3_idle", 64'(bus.arb_busy), 64'd0);
        chk_log(1, 0, 0);
        bus.req_len[6*LENW +: LENW] = 4'd1;
        bus.req_valid[6] = 1'b1;
        bus.arb_gnt = 7'b1000000;
        step();
        bus.arb_gnt = '0;
        chk("t3_src6", 64'(bus.out_src), 64'd6);
        chk("t3_busy6", 64'(bus.arb_busy), 64'h7F);
        wait_idle(8);
        chk_log(2, 6, 0);
        bus.req_valid = '0;

        // Multi-hot grant: owner is the lowest bit, error flag is sticky.
        bus.req_len[3*LENW +: LENW] = 4'd1;
        bus.req_valid[3] = 1'b1;
        bus.arb_gnt = 7'b0101000;
        step();
        bus.arb_gnt = '0;
        chk("t4_src3", 64'(bus.out_src), 64'd3);
        chk("t4_err", 64'(bus.multi_gnt_err), 64'd1);
        wait_idle(8);
        chk_log(2, 3, 0);
        bus.req_valid = '0;
        bus.req_len[1*LENW +: LENW] = 4'd0;
        bus.req_valid[1] = 1'b1;
        bus.arb_gnt = 7'b0000010;
        step();
        bus.arb_gnt = '0;
        wait_idle(8);
        chk("t4_err_sticky", 64'(bus.multi_gnt_err), 64'd1);
        chk_log(1, 1, 0);
        bus.req_valid = '0;

        // Grant held during a requester-4 burst is ignored until the burst ends.
        bus.req_len[4*LENW +: LENW] = 4'd5;
        bus.req_valid[4] = 1'b1;
        bus.arb_gnt = 7'b0010000;
        step();
        bus.arb_gnt = 7'b0000001;
        bus.req_len[0*LENW +: LENW] = 4'd0;
        bus.req_valid[0] = 1'b1;
        wait_idle(12);
        chk_log(6, 4, 0);
        step();
        bus.arb_gnt = '0;
        chk("t5_src0", 64'(bus.out_src), 64'd0);
        chk("t5_busy0", 64'(bus.arb_busy), 64'h7F);
        wait_idle(8);
        chk_log(1, 0, 1);
        bus.req_valid = '0;

        // Reset on beat 2 of a len-7 burst, then a normal grant.
        bus.req_len[1*LENW +: LENW] = 4'd7;
        bus.req_valid[1] = 1'b1;
        bus.arb_gnt = 7'b0000010;
        step();
        bus.arb_gnt = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", 64'(bus.arb_busy), 64'd0);
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_ready", 64'(bus.req_ready), 64'd0);
        chk("t6_err", 64'(bus.multi_gnt_err), 64'd0);
        bus.req_valid = '0;
        log_q.delete();
        bus.req_len[3*LENW +: LENW] = 4'd1;
        bus.req_valid[3] = 1'b1;
        bus.arb_gnt = 7'b0001000;
        step();
        bus.arb_gnt = '0;
        chk("t6_src3", 64'(bus.out_src), 64'd3);
        wait_idle(8);
        chk_log(2, 3, 2);
        bus.req_valid = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ah_gnt_burst_ctrl.md
# ah_gnt_burst_ctrl

Burst-transfer stage directly downstream of the 7-way LRU arbiter. It latches the arbiter's one-hot grant and locks the shared output channel to the winning requester for a programmable burst of beats. It muxes that requester's payload onto a valid/ready output and drives the arbiter's `gnt_busy` inputs so no new grant is issued until the burst completes.

## Interface
- `NREQ`, 7, number of requesters; must match arbiter width.
- `DW`, 32, payload width per beat.
- `LENW`, 4, burst-length field width; burst beats = `req_len` + 1 (1..16).
- `SRCW`, 3, width of source index; must satisfy `2**SRCW >= NREQ`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `arb_gnt` input NREQ: one-hot grant from the arbiter's `gnt`.
- `arb_busy` output NREQ: to the arbiter's `gnt_busy`; bit i=1 means requester i must not be granted.
- `req_valid` input NREQ: per-requester beat valid.
- `req_len` input NREQ*LENW: per-requester burst length minus one; slice i = bits [i*LENW +: LENW].
- `req_data` input NREQ*DW: per-requester beat payload; slice i = bits [i*DW +: DW].
- `req_ready` output NREQ: per-requester beat accept.
- `out_valid` output 1: output beat valid.
- `out_data` output DW: output beat payload.
- `out_src` output SRCW: index of the current owner.
- `out_last` output 1: final beat of the burst.
- `out_ready` input 1: downstream accept.
- `multi_gnt_err` output 1: sticky flag, set when more than one grant bit is seen.

## Operation
- FSM states: IDLE, BURST.
- **IDLE:**
  - `arb_busy` = all zeros.
  - `req_ready`, `out_valid`, `out_last` = 0.
  - If `arb_gnt` != 0: latch owner = index of the lowest set bit, and `beats_left` = `req_len[owner]` (sampled this cycle). Go to BURST.
  - If `arb_gnt` has more than one bit set, set `multi_gnt_err`. Owner is still the lowest set bit.
  - If `arb_gnt` == 0: stay in IDLE.
- **BURST:**
  - `arb_busy` = all ones.
  - `out_valid` = `req_valid[owner]`.
  - `out_data` = `req_data[owner]`.
  - `out_src` = owner.
  - `req_ready[owner]` = `out_ready`; all other `req_ready` bits = 0.
  - `out_last` = (`beats_left` == 0) & `out_valid`.
- **Beat transfer:** occurs when `out_valid` & `out_ready`.
  - If `beats_left` != 0, decrement it.
  - If `beats_left` == 0, return to IDLE.
- **Stall:** if `req_valid[owner]` drops mid-burst, `out_valid` = 0 and `beats_left` holds. No timeout.
- `arb_gnt` is ignored in BURST, including any nonzero value.
- `req_len` is sampled only at grant capture. Later changes have no effect on a burst in progress.
- **Arithmetic:** `beats_left` is LENW bits, decrement only, never wraps (guarded by the `== 0` check). Owner is SRCW bits.
- Outputs `out_valid`, `out_last` and `req_ready` are combinational from FSM state plus `req_valid` / `out_ready`.
- **Reset values:**
  - State = IDLE, owner = 0, `beats_left` = 0, `multi_gnt_err` = 0.
  - Hence `arb_busy` = 0, `out_valid` = 0, `out_last` = 0, `req_ready` = 0, `out_src` = 0.
  - `out_data` = `req_data[0]` in IDLE; it is don't-care while `out_valid` = 0.
- Reset mid-burst: the next rising edge with `rst`=1 returns to IDLE. The partial burst is abandoned and `arb_busy` releases the following cycle.

## Timing
- Grant sampled at edge N; at N+1 the FSM is in BURST, `arb_busy` = all ones, and the first beat can transfer the same cycle.
- Burst of L+1 beats with no stalls: BURST lasts exactly L+1 cycles.
  - The last-beat transfer occurs at edge N+1+L, with the FSM in IDLE afterwards.
  - `arb_busy` deasserts in that cycle.
- Minimum spacing between consecutive bursts: one IDLE cycle. The earliest next grant sample is the cycle after the last beat.
- `arb_busy` is registered (state-derived) and never glitches within a cycle.
- `multi_gnt_err` sets at the edge after the offending grant and holds until `rst`.

## Test plan
- **Single burst:** `arb_gnt`=7'b0000100, `req_len[2]`=3, `req_valid[2]`=1, `out_ready`=1.
  - 4 beats, `out_src`=2, `out_last` on the 4th beat only.
  - `arb_busy`=7'h7F for 4 cycles, then 0.
- **Back-pressure and source stall:** owner 5, len 2. Toggle `out_ready` and drop `req_valid[5]` for 2 cycles mid-burst.
  - Exactly 3 beats transfer in order.
  - `beats_left` holds during stalls.
  - `req_ready[5]` tracks `out_ready`; other `req_ready` bits stay 0.
- **Single-beat burst:** len=0 on requester 0.
  - One beat with `out_last`=1.
  - IDLE the next cycle; a grant to requester 6 in that cycle is accepted.
- **Multi-hot grant:** `arb_gnt`=7'b0101000.
  - Owner=3 and `multi_gnt_err`=1 next cycle.
  - The flag persists through a later clean burst until `rst`.
- **Grant during burst:** `arb_gnt`=7'b0000001 asserted throughout a requester-4 len-5 burst.
  - Ignored; owner stays 4 for 6 beats, then requester 0 is taken.
- **Reset mid-burst:** `rst` pulsed on beat 2 of a len-7 burst.
  - Next cycle: `arb_busy`=0, `out_valid`=0, `req_ready`=0, `multi_gnt_err`=0.
  - A new grant is accepted normally afterwards.
